instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: FIFO_DEPTH, 4, instruction buffer entries; power of two, at least 2.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-005 REDIRECT_VALID  in  1  branch/jump redirect from execute.
REQ-006 REDIRECT_PC  in  32  redirect target.
REQ-007 IMEM_REQ_VALID  out  1  fetch request valid.
REQ-008 IMEM_REQ_READY  in  1  memory accepts request.
REQ-009 IMEM_REQ_ADDR  out  32  fetch address.
REQ-010 IMEM_RSP_VALID  in  1  response valid; cannot be back-pressured.
REQ-011 IMEM_RSP_DATA  in  32  fetched instruction word.
REQ-012 DEC_VALID  out  1  instruction available to decode.
REQ-013 DEC_READY  in  1  decode accepts instruction.
REQ-014 DEC_PC  out  32  PC of the presented instruction.
REQ-015 DEC_INSTRUCTION  out  32  presented instruction word.

Function
REQ-016 Fetch PC register: +4 on each accepted request (IMEM_REQ_VALID && IMEM_REQ_READY); wraps 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-017 IMEM_REQ_ADDR = fetch PC register; bits [1:0] are always 0.
REQ-018 Credit rule: IMEM_REQ_VALID = (outstanding + FIFO occupancy < FIFO_DEPTH) && !REDIRECT_VALID; FIFO overflow is impossible by construction.
REQ-019 Outstanding counter (width clog2(FIFO_DEPTH+1)): +1 on request accept, -1 on IMEM_RSP_VALID; both in the same cycle leave it unchanged.
REQ-020 Responses arrive in request order, at least one cycle after acceptance; each response carries its request address from an internal in-order address queue, or equivalently, from a response-PC counter.
REQ-021 A response not marked for discard is written into the FIFO with its PC at the clock edge; no bypass; minimum latency response -> DEC_VALID is 1 cycle.
REQ-022 DEC_VALID = FIFO not empty && !REDIRECT_VALID; DEC_PC/DEC_INSTRUCTION = FIFO head; pop on DEC_VALID && DEC_READY.
REQ-023 Push and pop in the same cycle are both honoured, including when the FIFO is full, because the credit rule guarantees a slot.
REQ-024 Redirect has priority over all other events: fetch PC <= {REDIRECT_PC[31:2],2'b00}; FIFO flushed; no pop; no request accepted in that cycle.
REQ-025 On redirect, the drop counter <= outstanding minus (1 if IMEM_RSP_VALID that cycle); the response arriving in the redirect cycle is discarded.
REQ-026 Each response while drop counter > 0: discard, drop counter -1, outstanding -1; new requests may issue meanwhile because responses are in order.
REQ-027 Back-to-back redirects: each re-computes the drop counter per REQ-025; the last target wins.
REQ-028 Empty FIFO: DEC_PC and DEC_INSTRUCTION hold last head value (no X); no underflow on DEC_READY.

Reset
REQ-029 RST_N low asynchronously sets: fetch PC = RESET_PC, outstanding = 0, drop = 0, FIFO empty, DEC_VALID = 0, IMEM_REQ_VALID = 0, DEC_PC = 0, DEC_INSTRUCTION = 32'h0000_0013 (NOP).
REQ-030 In-flight responses at reset are lost; memory is reset together with this unit.
REQ-031 First request (addr RESET_PC) is presented in the first cycle after RST_N deasserts.

Structure
REQ-032 Shared package holds XLEN = 32, INSTR_NOP = 32'h0000_0013, DEFAULT_RESET_PC, and the {pc, instruction} FIFO entry struct.
REQ-033 One sub-module, sync_fifo (parameterised width/depth, push/pop/flush, count output), holds the instruction buffer; control stays in the top.

Verification
REQ-034 Reset, IMEM_REQ_READY=1, 1-cycle memory, DEC_READY=1 -> DEC_PC sequence 0,4,8,C..., one instruction per cycle after fill.
REQ-035 DEC_READY=0 for 10 cycles -> exactly FIFO_DEPTH requests issued; IMEM_REQ_VALID low thereafter; no loss on release.
REQ-036 3 requests outstanding (3-cycle memory), redirect to 32'h0000_0103 -> 3 old responses dropped; next DEC_PC 32'h0000_0100.
REQ-037 Redirect coincident with response, and with DEC_VALID&&DEC_READY -> response discarded, no pop, DEC_VALID 0 that cycle.
REQ-038 Redirect to 32'hFFFF_FFF8 -> DEC_PC FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 RST_N asserted mid-stream with 2 outstanding -> outputs at reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-path types and constants: datapath width, NOP encoding, reset PC
// and the {pc, instruction} buffer entry.
package instruction_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Word-align a target address.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_sync_fifo.sv
// Synchronous FIFO with push/pop/flush and an occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               data_i,
  input  logic                           pop_i,
  input  logic                           flush_i,
  output logic [WIDTH-1:0]               head_o,
  output logic [$clog2(DEPTH + 1)-1:0]   count_o,
  output logic                           empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only consumed while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// In-order instruction fetch: credit-limited requests to instruction memory,
// a buffer of {pc, instruction} for decode, and redirect with stale-response drop.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  output logic            dec_valid_o,
  input  logic            dec_ready_i,
  output logic [XLEN-1:0] dec_pc_o,
  output logic [XLEN-1:0] dec_instruction_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     hold_q, hold_d;
  fetch_entry_t     fifo_head;
  fetch_entry_t     push_entry;
  logic             credit_ok;
  logic             req_accept;
  logic             rsp_keep;
  logic             fifo_empty;
  logic             dec_pop;

  // In-flight requests plus buffered entries never exceed the buffer size.
  assign credit_ok = (SUM_W'(outstanding_q) + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH);

  assign imem_req_valid_o = rst_n_i && credit_ok && !redirect_valid_i;
  assign imem_req_addr_o  = fetch_pc_q;
  assign req_accept       = imem_req_valid_o && imem_req_ready_i;

  assign rsp_keep   = imem_rsp_valid_i && !redirect_valid_i && (drop_q == '0);
  assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data_i};

  assign dec_valid_o       = rst_n_i && !fifo_empty && !redirect_valid_i;
  assign dec_pop           = dec_valid_o && dec_ready_i;
  assign dec_pc_o          = fifo_empty ? hold_q.pc    : fifo_head.pc;
  assign dec_instruction_o = fifo_empty ? hold_q.instr : fifo_head.instr;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    hold_d        = fifo_empty ? hold_q : fifo_head;

    case ({req_accept, imem_rsp_valid_i})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (redirect_valid_i) begin
      // Everything still in flight is stale; the response landing now is dropped too.
      fetch_pc_d = align_pc(redirect_pc_i);
      rsp_pc_d   = align_pc(redirect_pc_i);
      drop_d     = outstanding_q - CNT_W'(imem_rsp_valid_i);
    end else begin
      if (req_accept) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (imem_rsp_valid_i && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
      if (rsp_keep) rsp_pc_d = rsp_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      hold_q        <= '{pc: '0, instr: INSTR_NOP};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      hold_q        <= hold_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_ibuf (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (rsp_keep),
    .data_i  (push_entry),
    .pop_i   (dec_pop),
    .flush_i (redirect_valid_i),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a fixed-latency in-order memory;
// every fetched word is the bitwise inverse of its address.
module tb_instruction_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        dec_valid_o;
  logic        dec_ready_i = 1'b0;
  logic [31:0] dec_pc_o;
  logic [31:0] dec_instruction_o;

  always #5 clk_i = ~clk_i;

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_pc_i     (redirect_pc_i),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_req_addr_o   (imem_req_addr_o),
    .imem_rsp_valid_i  (imem_rsp_valid_i),
    .imem_rsp_data_i   (imem_rsp_data_i),
    .dec_valid_o       (dec_valid_o),
    .dec_ready_i       (dec_ready_i),
    .dec_pc_o          (dec_pc_o),
    .dec_instruction_o (dec_instruction_o)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  mreq_t       mq[$];
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned n_acc = 0;
  int unsigned n_pop = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_pc = '0;
  logic        stream_chk = 1'b0;
  logic        s_req_valid, s_dec_valid;
  logic [31:0] s_req_addr, s_dec_pc, s_dec_instr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step();
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = ~mq[0].addr;
      mq.delete(0);
    end
    #1;
    s_req_valid = imem_req_valid_o;
    s_req_addr  = imem_req_addr_o;
    s_dec_valid = dec_valid_o;
    s_dec_pc    = dec_pc_o;
    s_dec_instr = dec_instruction_o;
    if (imem_req_valid_o && imem_req_ready_i) begin
      mq.push_back('{addr: imem_req_addr_o, due: cyc + lat});
      n_acc++;
    end
    if (stream_chk && dec_valid_o && dec_ready_i) begin
      check("dec_pc", dec_pc_o, exp_pc);
      check("dec_instr", dec_instruction_o, ~exp_pc);
      exp_pc += 32'd4;
      n_pop++;
    end
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst_n_i          = 1'b0;
    redirect_valid_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    mq.delete();
    #1;
    check({tag, "_req_valid"}, 32'(imem_req_valid_o), 32'd0);
    check({tag, "_dec_valid"}, 32'(dec_valid_o), 32'd0);
    check({tag, "_dec_pc"}, dec_pc_o, 32'h0000_0000);
    check({tag, "_dec_instr"}, dec_instruction_o, 32'h0000_0013);
    check({tag, "_req_addr"}, imem_req_addr_o, 32'h0000_0000);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    exp_pc  = '0;
    n_acc   = 0;
    n_pop   = 0;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = target;
    step();
    check("redir_dec_valid", 32'(s_dec_valid), 32'd0);
    check("redir_req_valid", 32'(s_req_valid), 32'd0);
    redirect_valid_i = 1'b0;
    exp_pc = {target[31:2], 2'b00};
  endtask

  initial begin
    // Reset state and first request straight after release
    do_reset("rst");
    imem_req_ready_i = 1'b1;
    dec_ready_i      = 1'b1;
    lat              = 1;
    stream_chk       = 1'b1;
    step();
    check("first_req_valid", 32'(s_req_valid), 32'd1);
    check("first_req_addr", s_req_addr, 32'h0000_0000);
    check("empty_dec_valid", 32'(s_dec_valid), 32'd0);
    check("empty_dec_pc", s_dec_pc, 32'h0000_0000);
    check("empty_dec_instr", s_dec_instr, 32'h0000_0013);

    // Streaming with 1-cycle memory: one instruction per cycle after fill
    repeat (19) step();
    check("stream_pops", n_pop, 32'd18);

    // Redirect coincident with a response and a decode handshake
    n_pop = 0;
    redirect(32'h0000_0200);
    repeat (6) step();
    check("redir_pops", n_pop, 32'd4);

    // Back-to-back redirects, last wins; address wrap at the top
    n_pop = 0;
    redirect(32'h0000_0300);
    redirect(32'hFFFF_FFF9);
    step();
    check("wrap_req_addr", s_req_addr, 32'hFFFF_FFF8);
    repeat (5) step();
    check("wrap_pops", n_pop, 32'd4);
    check("wrap_next_pc", exp_pc, 32'h0000_0008);

    // Decode stalled: exactly FIFO_DEPTH requests, then nothing lost on release
    do_reset("rst2");
    dec_ready_i = 1'b0;
    repeat (10) step();
    check("stall_accepts", n_acc, 32'd4);
    check("stall_req_valid", 32'(s_req_valid), 32'd0);
    check("stall_dec_valid", 32'(s_dec_valid), 32'd1);
    dec_ready_i = 1'b1;
    repeat (12) step();
    check("release_pops", n_pop, 32'd12);

    // Three requests in flight on a 3-cycle memory, then redirect
    do_reset("rst3");
    lat = 3;
    repeat (3) step();
    check("drop_accepts", n_acc, 32'd3);
    redirect(32'h0000_0103);
    check("drop_exp_pc", exp_pc, 32'h0000_0100);
    repeat (3) step();
    check("drop_no_stale", 32'(s_dec_valid), 32'd0);
    repeat (7) step();
    check("drop_pops_seen", 32'(n_pop != 0), 32'd1);

    // Reset mid-stream with two responses in flight
    do_reset("rst4");
    lat = 2;
    repeat (6) step();
    do_reset("mid_rst");
    step();
    check("restart_req_valid", 32'(s_req_valid), 32'd1);
    check("restart_req_addr", s_req_addr, 32'h0000_0000);
    repeat (8) step();
    check("restart_pops", n_pop, 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
